// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the immediate-extension unit: extension modes and the
// default datapath widths that decode also builds against.
package imm_extend_pipe_pkg;

   localparam int DEF_REG_DATA_WIDTH = 16;
   localparam int DEF_IMM_MAX_WIDTH  = 12;
   localparam int DEF_SHL_AMT        = 1;
   localparam int DEF_WSEL_WIDTH     = 4;

   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      MODE_SEXT     = 2'd0,
      MODE_ZEXT     = 2'd1,
      MODE_SEXT_SHL = 2'd2,
      MODE_UPPER    = 2'd3
   } imm_mode_e;

   // A field width of zero or wider than the immediate port cannot be honoured.
   function automatic logic width_illegal(input int fw, input int max_w);
      return (fw == 0) || (fw > max_w);
   endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle between decode, the extension unit and execute.
// valid/ready: a transfer happens on a rising edge where valid && ready; the
// sender holds valid high and payload stable until that edge.
interface imm_extend_pipe_if #(
   parameter int REG_DATA_WIDTH = imm_extend_pipe_pkg::DEF_REG_DATA_WIDTH,
   parameter int IMM_MAX_WIDTH  = imm_extend_pipe_pkg::DEF_IMM_MAX_WIDTH,
   parameter int WSEL_WIDTH     = imm_extend_pipe_pkg::DEF_WSEL_WIDTH
);

   logic                      in_valid;
   logic                      in_ready;
   logic [IMM_MAX_WIDTH-1:0]  data_in;
   logic [WSEL_WIDTH-1:0]     field_width;
   logic [1:0]                mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [REG_DATA_WIDTH-1:0] data_out;
   logic                      width_err;
   logic                      ovf;

   modport slave (
      input  in_valid, data_in, field_width, mode, out_ready,
      output in_ready, out_valid, data_out, width_err, ovf
   );

   modport master (
      output in_valid, data_in, field_width, mode, out_ready,
      input  in_ready, out_valid, data_out, width_err, ovf
   );

endinterface

// File: rtl/imm_extend_pipe_ext_core.sv
// Combinational extension datapath: masks the active field, then produces the
// sign/zero/shifted/upper-placed result together with width_err and ovf.
module imm_extend_pipe_ext_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
   parameter int IMM_MAX_WIDTH  = DEF_IMM_MAX_WIDTH,
   parameter int SHL_AMT        = DEF_SHL_AMT,
   parameter int WSEL_WIDTH     = DEF_WSEL_WIDTH
) (
   input  logic [IMM_MAX_WIDTH-1:0]  i_data,
   input  logic [WSEL_WIDTH-1:0]     i_field_width,
   input  imm_mode_e                 i_mode,
   output logic [REG_DATA_WIDTH-1:0] o_data,
   output logic                      o_width_err,
   output logic                      o_ovf
);

   logic                      w_err;
   logic [WSEL_WIDTH-1:0]     w_fw;
   logic [REG_DATA_WIDTH-1:0] w_mask;
   logic [REG_DATA_WIDTH-1:0] w_field;
   logic                      w_sign;
   logic [REG_DATA_WIDTH-1:0] w_sext;
   logic [REG_DATA_WIDTH-1:0] w_shl;
   logic                      w_shl_ovf;
   logic [REG_DATA_WIDTH-1:0] w_upper;

   always_comb begin
      w_err   = width_illegal(int'(i_field_width), IMM_MAX_WIDTH);
      w_fw    = w_err ? WSEL_WIDTH'(IMM_MAX_WIDTH) : i_field_width;
      w_mask  = ~({REG_DATA_WIDTH{1'b1}} << w_fw);
      w_field = REG_DATA_WIDTH'(i_data) & w_mask;

      w_sign = 1'b0;
      for (int i = 0; i < IMM_MAX_WIDTH; i++) begin
         if (int'(w_fw) == i + 1) w_sign = i_data[i];
      end

      w_sext = w_field | (w_sign ? ~w_mask : '0);
      w_shl  = w_sext << SHL_AMT;

      // Every bit pushed out of the top must match the new MSB, or the offset changed.
      w_shl_ovf = 1'b0;
      for (int i = 0; i < REG_DATA_WIDTH; i++) begin
         if (i >= REG_DATA_WIDTH - SHL_AMT) w_shl_ovf = w_shl_ovf | (w_sext[i] ^ w_shl[REG_DATA_WIDTH-1]);
      end

      w_upper = w_field << (REG_DATA_WIDTH - int'(w_fw));
   end

   always_comb begin
      o_data      = '0;
      o_ovf       = 1'b0;
      o_width_err = w_err;
      case (i_mode)
         MODE_SEXT:     o_data = w_sext;
         MODE_ZEXT:     o_data = w_field;
         MODE_SEXT_SHL: begin
            o_data = w_shl;
            o_ovf  = w_shl_ovf;
         end
         MODE_UPPER:    o_data = w_upper;
         default:       o_data = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: combinational extension on the input side,
// results held in a 2-entry skid buffer so decode and execute stall independently.
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
   parameter int IMM_MAX_WIDTH  = DEF_IMM_MAX_WIDTH,
   parameter int SHL_AMT        = DEF_SHL_AMT,
   parameter int WSEL_WIDTH     = DEF_WSEL_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   imm_extend_pipe_if.slave io
);

   localparam int          ENTRY_W = REG_DATA_WIDTH + 2;
   localparam logic [1:0]  FULL    = 2'(BUF_DEPTH);

   logic [REG_DATA_WIDTH-1:0]            w_ext_data;
   logic                                 w_ext_err;
   logic                                 w_ext_ovf;
   logic [ENTRY_W-1:0]                   w_new;
   logic                                 w_push;
   logic                                 w_pop;
   logic [BUF_DEPTH-1:0][ENTRY_W-1:0]    r_entry;
   logic [1:0]                           r_count;

   imm_extend_pipe_ext_core #(
      .REG_DATA_WIDTH (REG_DATA_WIDTH),
      .IMM_MAX_WIDTH  (IMM_MAX_WIDTH),
      .SHL_AMT        (SHL_AMT),
      .WSEL_WIDTH     (WSEL_WIDTH)
   ) u_ext_core (
      .i_data        (io.data_in),
      .i_field_width (io.field_width),
      .i_mode        (imm_mode_e'(io.mode)),
      .o_data        (w_ext_data),
      .o_width_err   (w_ext_err),
      .o_ovf         (w_ext_ovf)
   );

   assign w_new = {w_ext_data, w_ext_err, w_ext_ovf};

   // in_ready comes from the registered count alone, never from out_ready.
   assign io.in_ready  = (r_count < FULL);
   assign io.out_valid = (r_count != 2'd0);
   assign {io.data_out, io.width_err, io.ovf} = r_entry[0];

   assign w_push = io.in_valid && io.in_ready;
   assign w_pop  = io.out_valid && io.out_ready;

   // Entry 0 is always the head; a pop shifts entry 1 forward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_entry <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_entry[r_count[0]] <= w_new;
               r_count             <= r_count + 2'd1;
            end
            2'b01: begin
               r_entry[0] <= r_entry[1];
               r_count    <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_entry[0] <= w_new;
               end else begin
                  r_entry[0] <= r_entry[1];
                  r_entry[1] <= w_new;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed cases plus random traffic against an
// arithmetic reference model, on a 16/12 build and a 16/16 build.
module tb_imm_extend_pipe;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_errors;

   logic [17:0] q_a[$];
   logic [17:0] q_b[$];
   int          out_cyc_a[$];
   int          acc_cyc_a;
   logic        rand_done;

   imm_extend_pipe_if #(.REG_DATA_WIDTH(16), .IMM_MAX_WIDTH(12), .WSEL_WIDTH(4)) bus_a ();
   imm_extend_pipe_if #(.REG_DATA_WIDTH(16), .IMM_MAX_WIDTH(16), .WSEL_WIDTH(5)) bus_b ();

   imm_extend_pipe #(
      .REG_DATA_WIDTH(16), .IMM_MAX_WIDTH(12), .SHL_AMT(1), .WSEL_WIDTH(4)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus_a)
   );

   imm_extend_pipe #(
      .REG_DATA_WIDTH(16), .IMM_MAX_WIDTH(16), .SHL_AMT(1), .WSEL_WIDTH(5)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: value arithmetic on the field, result packed {data, width_err, ovf}.
   function automatic logic [17:0] model(input longint d, input int fw, input int m,
                                         input int imw, input int rw, input int shl);
      int     w;
      logic   werr;
      logic   ov;
      longint f, sv, r, p, modv, lim;
      werr = (fw == 0) || (fw > imw);
      w    = werr ? imw : fw;
      f    = d % (64'sd1 <<< w);
      sv   = (f >= (64'sd1 <<< (w - 1))) ? f - (64'sd1 <<< w) : f;
      modv = 64'sd1 <<< rw;
      lim  = 64'sd1 <<< (rw - 1);
      ov   = 1'b0;
      case (m)
         0: r = sv;
         1: r = f;
         2: begin
            p  = sv * (64'sd1 <<< shl);
            r  = p;
            ov = (p < -lim) || (p >= lim);
         end
         default: r = f * (64'sd1 <<< (rw - w));
      endcase
      r = ((r % modv) + modv) % modv;
      return {r[15:0], werr, ov};
   endfunction

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
         if (q_a.size() == 0) begin
            check_eq("unexpected_out_a", 32'(bus_a.out_valid), 32'd0);
         end else begin
            check_eq("out_a", 32'({bus_a.data_out, bus_a.width_err, bus_a.ovf}), 32'(q_a.pop_front()));
            out_cyc_a.push_back(cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
         if (q_b.size() == 0) begin
            check_eq("unexpected_out_b", 32'(bus_b.out_valid), 32'd0);
         end else begin
            check_eq("out_b", 32'({bus_b.data_out, bus_b.width_err, bus_b.ovf}), 32'(q_b.pop_front()));
         end
      end
   end

   // ---------------- drivers ----------------
   // Called at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
   task automatic send_a(input logic [11:0] d, input logic [3:0] fw, input logic [1:0] m,
                         input logic [17:0] exp);
      int waited;
      waited = 0;
      bus_a.in_valid    = 1'b1;
      bus_a.data_in     = d;
      bus_a.field_width = fw;
      bus_a.mode        = m;
      @(negedge clk);
      while (!bus_a.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus_a.in_ready) begin
         check_eq("accept_timeout_a", 32'(bus_a.in_ready), 32'd1);
      end else begin
         q_a.push_back(exp);
         acc_cyc_a = cyc;
      end
      @(posedge clk);
      #1;
      bus_a.in_valid = 1'b0;
      bus_a.data_in  = 12'($urandom);
   endtask

   task automatic send_b(input logic [15:0] d, input logic [4:0] fw, input logic [1:0] m,
                         input logic [17:0] exp);
      int waited;
      waited = 0;
      bus_b.in_valid    = 1'b1;
      bus_b.data_in     = d;
      bus_b.field_width = fw;
      bus_b.mode        = m;
      @(negedge clk);
      while (!bus_b.in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!bus_b.in_ready) check_eq("accept_timeout_b", 32'(bus_b.in_ready), 32'd1);
      else q_b.push_back(exp);
      @(posedge clk);
      #1;
      bus_b.in_valid = 1'b0;
   endtask

   task automatic send_rand_a();
      logic [11:0] d;
      logic [3:0]  fw;
      logic [1:0]  m;
      d  = 12'($urandom);
      fw = 4'($urandom_range(0, 15));
      m  = 2'($urandom_range(0, 3));
      send_a(d, fw, m, model(longint'(d), int'(fw), int'(m), 12, 16, 1));
   endtask

   task automatic send_rand_b();
      logic [15:0] d;
      logic [4:0]  fw;
      logic [1:0]  m;
      d  = 16'($urandom);
      fw = 5'($urandom_range(0, 31));
      m  = 2'($urandom_range(0, 3));
      send_b(d, fw, m, model(longint'(d), int'(fw), int'(m), 16, 16, 1));
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && waited < 500) begin
         waited++;
         @(posedge clk);
      end
      #1;
      check_eq("drain_a", 32'(q_a.size()), 32'd0);
      check_eq("drain_b", 32'(q_b.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_errors  = 0;
      acc_cyc_a = 0;
      rand_done = 1'b0;
      rst_n     = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.data_in = '0; bus_a.field_width = '0;
      bus_a.mode = '0; bus_a.out_ready = 1'b1;
      bus_b.in_valid = 1'b0; bus_b.data_in = '0; bus_b.field_width = '0;
      bus_b.mode = '0; bus_b.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check_eq("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
      check_eq("rst_data_out",  32'(bus_a.data_out),  32'd0);
      check_eq("rst_width_err", 32'(bus_a.width_err), 32'd0);
      check_eq("rst_ovf",       32'(bus_a.ovf),       32'd0);
      check_eq("rst_b_valid",   32'(bus_b.out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First result one cycle after acceptance
      send_a(12'hFFA, 4'd4, 2'd0, {16'hFFFA, 2'b00});
      check_eq("lat_valid", 32'(bus_a.out_valid), 32'd1);
      check_eq("lat_data",  32'(bus_a.data_out),  32'h0000FFFA);
      @(posedge clk);
      #1;

      // Mode sweep, back-to-back
      out_cyc_a.delete();
      send_a(12'h0F8, 4'd8, 2'd1, {16'h00F8, 2'b00});
      send_a(12'h0F8, 4'd8, 2'd0, {16'hFFF8, 2'b00});
      send_a(12'h0F8, 4'd8, 2'd2, {16'hFFF0, 2'b00});
      send_a(12'h0F8, 4'd8, 2'd3, {16'hF800, 2'b00});
      repeat (3) @(posedge clk);
      #1;
      check_eq("sweep_count", 32'(out_cyc_a.size()), 32'd4);
      if (out_cyc_a.size() == 4)
         check_eq("sweep_consecutive", 32'(out_cyc_a[3] - out_cyc_a[0]), 32'd3);

      // Illegal widths fall back to the full field
      send_a(12'h800, 4'd0,  2'd0, {16'hF800, 2'b10});
      send_a(12'h800, 4'd13, 2'd0, {16'hF800, 2'b10});
      send_a(12'h800, 4'd15, 2'd1, {16'h0800, 2'b10});
      send_a(12'hABC, 4'd12, 2'd3, {16'hABC0, 2'b00});
      wait_drain();

      // Backpressure: two accepted, third held until first drain
      bus_a.out_ready = 1'b0;
      send_a(12'h011, 4'd12, 2'd1, {16'h0011, 2'b00});
      send_a(12'h022, 4'd12, 2'd1, {16'h0022, 2'b00});
      check_eq("bp_full_in_ready", 32'(bus_a.in_ready), 32'd0);
      fork
         send_a(12'h033, 4'd12, 2'd1, {16'h0033, 2'b00});
         begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("bp_held_in_ready", 32'(bus_a.in_ready), 32'd0);
            check_eq("bp_held_queue",    32'(q_a.size()),     32'd2);
            check_eq("bp_held_data",     32'(bus_a.data_out), 32'h00000011);
            out_cyc_a.delete();
            bus_a.out_ready = 1'b1;
         end
      join
      if (out_cyc_a.size() > 0)
         check_eq("bp_accept_after_drain", 32'(acc_cyc_a - out_cyc_a[0]), 32'd1);
      wait_drain();

      // Overflow cases on the 16-bit-immediate build
      send_b(16'h4000, 5'd16, 2'd2, {16'h8000, 2'b01});
      send_b(16'hC000, 5'd16, 2'd2, {16'h8000, 2'b00});
      send_b(16'h8000, 5'd0,  2'd0, {16'h8000, 2'b10});
      wait_drain();

      // Random traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) send_rand_a();
            rand_done = 1'b1;
         end
         begin
            for (int i = 0; i < 120; i++) send_rand_b();
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus_a.out_ready = ($urandom_range(0, 3) != 0);
               bus_b.out_ready = ($urandom_range(0, 2) != 0);
            end
            bus_a.out_ready = 1'b1;
            bus_b.out_ready = 1'b1;
         end
      join
      wait_drain();

      // Asynchronous reset with a full buffer
      bus_a.out_ready = 1'b0;
      send_a(12'h5A5, 4'd12, 2'd1, {16'h05A5, 2'b00});
      send_a(12'h3C3, 4'd12, 2'd1, {16'h03C3, 2'b00});
      check_eq("mid_full", 32'(bus_a.in_ready), 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      check_eq("mid_rst_in_ready",  32'(bus_a.in_ready),  32'd1);
      check_eq("mid_rst_data_out",  32'(bus_a.data_out),  32'd0);
      q_a.delete();
      q_b.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      bus_a.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("post_rst_no_stale", 32'(bus_a.out_valid), 32'd0);
      send_a(12'h07F, 4'd7, 2'd0, {16'hFFFF, 2'b00});
      check_eq("post_rst_valid", 32'(bus_a.out_valid), 32'd1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      check_eq("global_timeout", 32'(rand_done), 32'd2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the datapath. Takes a variable-width immediate field and extends it to the register data width.
- Four modes: sign-extend, zero-extend, sign-extend-and-shift for branch offsets, and upper-placement for load-upper.
- Sits between instruction decode and the ALU operand mux.
- valid/ready handshaking and a 2-entry skid buffer let decode stall independently of execute.

Parameters:
REG_DATA_WIDTH, 16, output data width
IMM_MAX_WIDTH, 12, widest accepted immediate field; must be ≤ REG_DATA_WIDTH
SHL_AMT, 1, left shift applied in SEXT_SHL mode
WSEL_WIDTH, 4, width of field_width port; must satisfy 2^WSEL_WIDTH > IMM_MAX_WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a request
in_ready  output  1  unit can accept a request this cycle
data_in  input  IMM_MAX_WIDTH  immediate; bits at and above field_width are ignored
field_width  input  WSEL_WIDTH  active field width in bits; legal range 1..IMM_MAX_WIDTH
mode  input  2  0=SEXT, 1=ZEXT, 2=SEXT_SHL, 3=UPPER
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
data_out  output  REG_DATA_WIDTH  extended result
width_err  output  1  field_width was illegal for this result
ovf  output  1  SEXT_SHL shift lost significant bits

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty; out_valid=0, in_ready=1, data_out=0, width_err=0, ovf=0. Any in-flight request is discarded. Outputs stay at reset values until the first accepted request has propagated.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid must stay high and inputs stable until accepted. out_valid stays high and outputs stay stable until consumed.
- Latency: a result accepted at edge N appears at out_valid after edge N (1 cycle), provided the buffer was empty.
- Throughput: 1 per cycle while out_ready stays high.
- Buffer: 2-entry skid buffer with an occupancy count of 0..2.
  - in_ready = (count < 2), taken from registered state only; there is no combinational path from out_ready to in_ready.
  - Simultaneous input and output transfer: count unchanged, order preserved (FIFO).
  - count=2: in_ready=0. count=0: out_valid=0.
- Width handling:
  - fw = field_width. If fw is 0 or greater than IMM_MAX_WIDTH, then fw = IMM_MAX_WIDTH and width_err=1 for that result; otherwise width_err=0.
  - f = data_in[fw-1:0]; s = data_in[fw-1].
- Mode results:
  - SEXT: data_out = f with s replicated to REG_DATA_WIDTH.
  - ZEXT: data_out = f with zeros above.
  - SEXT_SHL: sign-extend f, then shift left by SHL_AMT and truncate to REG_DATA_WIDTH. ovf=1 iff any shifted-out bit differs from the result MSB.
  - UPPER: data_out = f << (REG_DATA_WIDTH - fw), with low bits zero.
  - ovf=0 in every mode other than SEXT_SHL.
- Where computation happens: extension is combinational on the input side; each buffer entry stores data_out, width_err and ovf.

Decomposition:
- Shared package/header holds:
  - Mode constants MODE_SEXT=0, MODE_ZEXT=1, MODE_SEXT_SHL=2, MODE_UPPER=3.
  - Default width constants, reused by decode.
- Sub-module ext_core (purely combinational): performs the field mask, extend, shift, width_err and ovf computation.
- Top-level imm_extend_pipe: holds the 2-entry buffer, count and handshake logic.

Test Plan:
- Reset, then data_in=12'hFFA, field_width=4, mode=SEXT, out_ready=1 → one cycle later out_valid=1, data_out=16'hFFFA, width_err=0, ovf=0.
- Mode sweep on data_in=12'h0F8, field_width=8 (back-to-back, out_ready=1):
  - ZEXT → 16'h00F8
  - SEXT → 16'hFFF8
  - SEXT_SHL → 16'hFFF0, ovf=0
  - UPPER → 16'hF800
  - All four results are delivered on consecutive cycles.
- Illegal widths:
  - field_width=0, data_in=12'h800, SEXT → data_out=16'hF800, width_err=1.
  - field_width=13 gives the same result.
- Backpressure:
  - Hold out_ready=0 and offer 3 requests → first 2 accepted, in_ready=0 after the second, third held.
  - Raise out_ready → results emerge in order; the third is accepted the cycle after the first drain; no loss or duplication.
- Overflow, with REG_DATA_WIDTH=16, IMM_MAX_WIDTH=16 build:
  - field_width=16, data_in=16'h4000, SEXT_SHL → data_out=16'h8000, ovf=1.
  - data_in=16'hC000 → data_out=16'h8000, ovf=0.
- Reset mid-operation: with count=2, pulse rst_n low asynchronously (between edges) → out_valid=0, in_ready=1 immediately; no stale result after release.
